// File: rtl/uart_pkg.sv
// Shared UART types: serializer state encoding and frame data width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Enqueue/status bus between a memory-mapped wrapper (master) and the buffered UART TX (slave).
interface uart_tx_buffered_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_char;
    logic                      tx_enqueue;
    logic                      tx_fifo_full;
    logic                      tx_fifo_empty;
    logic                      tx_idle;
    logic                      tx_overflow;

    modport master (
        output tx_char, tx_enqueue,
        input  tx_fifo_full, tx_fifo_empty, tx_idle, tx_overflow
    );

    modport slave (
        input  tx_char, tx_enqueue,
        output tx_fifo_full, tx_fifo_empty, tx_idle, tx_overflow
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer (8E1 with UART_TX_PARITY_EN): state machine, baud counter, shift register.
// Handshake: valid means a byte is at the FIFO head; deq pulses for one clock when that byte is consumed.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int BAUD_DIVIDE = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      deq,
    output logic                      uart_tx,
    output uart_tx_state_t            state
);

    localparam int                BW        = (BAUD_DIVIDE > 2) ? $clog2(BAUD_DIVIDE) : 1;
    localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_DIVIDE - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_n;
    logic [BW-1:0]             baud_cnt, baud_n;
    logic [2:0]                bit_cnt, bit_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic                      tx_n;
    logic                      baud_last;
`ifdef UART_TX_PARITY_EN
    logic                      parity, parity_n;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            uart_tx  <= tx_n;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift;
        deq       = 1'b0;
        tx_n      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_n  = parity;
`endif
        baud_last = (baud_cnt == BAUD_LAST);

        if (state != IDLE) begin
            baud_n = baud_last ? '0 : baud_cnt + BW'(1);
        end

        case (state)
            IDLE: begin
                if (valid) begin
                    deq     = 1'b1;
                    shift_n = data;
`ifdef UART_TX_PARITY_EN
                    parity_n = ^data;
`endif
                    state_n = START;
                    baud_n  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) state_n = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next start bit so frames are gap-free.
                if (baud_last) begin
                    if (valid) begin
                        deq     = 1'b1;
                        shift_n = data;
`ifdef UART_TX_PARITY_EN
                        parity_n = ^data;
`endif
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is registered, so derive it from the state being entered.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding uart_tx_serializer.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int BAUD_DIVIDE = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_buffered_if.slave  bus,
    output logic               uart_tx,
    output uart_tx_state_t     tx_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr, wr_n, rd_n;
    logic                      full_q, empty_q, overflow_q;
    logic                      do_enq, deq, fifo_valid;

    // Admission uses the registered full flag, so a same-cycle dequeue never rescues a write.
    assign do_enq     = bus.tx_enqueue && !full_q;
    assign fifo_valid = !empty_q;

    always_comb begin
        wr_n = wr_ptr;
        rd_n = rd_ptr;
        if (do_enq) wr_n = wr_ptr + PW'(1);
        if (deq)    rd_n = rd_ptr + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_n;
            rd_ptr  <= rd_n;
            full_q  <= (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
            empty_q <= (wr_n == rd_n);
            if (bus.tx_enqueue && full_q) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr[AW-1:0]] <= bus.tx_char;
    end

    uart_tx_serializer #(
        .BAUD_DIVIDE (BAUD_DIVIDE)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .valid   (fifo_valid),
        .data    (mem[rd_ptr[AW-1:0]]),
        .deq     (deq),
        .uart_tx (uart_tx),
        .state   (tx_state)
    );

    assign bus.tx_fifo_full  = full_q;
    assign bus.tx_fifo_empty = empty_q;
    assign bus.tx_overflow   = overflow_q;
    assign bus.tx_idle       = empty_q && (tx_state == IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered (BAUD_DIVIDE=4, FIFO_DEPTH=8); parity cases need UART_TX_PARITY_EN.
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_EN     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_EN     = 1'b0;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BAUD;

    logic           clk;
    logic           reset;
    logic           uart_tx;
    uart_tx_state_t tx_state;
    int             n_cmp;
    int             n_err;
    logic [7:0]     exp_q[$];

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(
        .BAUD_DIVIDE (BAUD),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .uart_tx  (uart_tx),
        .tx_state (tx_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Line waveform of one frame, one bit per clock, first clock in bit 0.
    function automatic logic [63:0] exp_frame(input logic [7:0] b);
        logic [63:0] v;
        logic        bv;
        v = '0;
        for (int j = 0; j < FRAME_BITS; j++) begin
            if (j == 0)                    bv = 1'b0;
            else if (j <= 8)               bv = b[j-1];
            else if (PAR_EN && j == 9)     bv = ^b;
            else                           bv = 1'b1;
            for (int c = 0; c < BAUD; c++) v[j*BAUD+c] = bv;
        end
        return v;
    endfunction

    // Driver tasks
    task automatic do_reset();
        reset          = 1'b0;
        bus.tx_enqueue = 1'b0;
        bus.tx_char    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic enqueue(input logic [7:0] b, input bit push);
        bus.tx_char    = b;
        bus.tx_enqueue = 1'b1;
        if (push) exp_q.push_back(b);
        @(negedge clk);
        bus.tx_enqueue = 1'b0;
    endtask

    task automatic capture(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = uart_tx;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, output logic [63:0] v);
        logic [7:0] b;
        b = exp_q.pop_front();
        capture(FRAME_CLKS, v);
        check(tag, v, exp_frame(b));
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] ones60;
        logic [7:0]  tbl [9];

        n_cmp  = 0;
        n_err  = 0;
        ones60 = 64'h0FFF_FFFF_FFFF_FFFF;
        tbl    = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h81, 8'hEE};

        do_reset();
        check("rst_uart_tx",  uart_tx, 1);
        check("rst_empty",    bus.tx_fifo_empty, 1);
        check("rst_full",     bus.tx_fifo_full, 0);
        check("rst_idle",     bus.tx_idle, 1);
        check("rst_overflow", bus.tx_overflow, 0);
        check("rst_state",    tx_state, IDLE);

        // Single byte from idle
        enqueue(8'h55, 1'b1);
        check("enq_empty_fall", bus.tx_fifo_empty, 0);
        check("enq_line_high",  uart_tx, 1);
        @(negedge clk);
        check("start_latency",  uart_tx, 0);
        check_frame("frame_55", v);
        check("idle_after_55",  bus.tx_idle, 1);
        check("empty_after_55", bus.tx_fifo_empty, 1);

        // Two consecutive enqueues, gap-free frames
        enqueue(8'hA5, 1'b1);
        enqueue(8'h3C, 1'b1);
        check_frame("frame_a5", v);
        check_frame("frame_3c", v);
        check("idle_after_pair", bus.tx_idle, 1);

        // Fill behind a busy serializer, ninth byte dropped
        enqueue(8'hF0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            enqueue(tbl[i], i < 8);
            if (i == 6) check("full_after_7", bus.tx_fifo_full, 0);
            if (i == 7) begin
                check("full_after_8",     bus.tx_fifo_full, 1);
                check("no_overflow_yet",  bus.tx_overflow, 0);
            end
            if (i == 8) check("overflow_after_9", bus.tx_overflow, 1);
        end
        repeat (FRAME_CLKS - 8) @(negedge clk);
        for (int i = 0; i < 8; i++) check_frame($sformatf("burst_%0d", i), v);
        capture(60, v);
        check("no_ninth_frame",   v, ones60);
        check("overflow_sticky",  bus.tx_overflow, 1);
        check("idle_after_burst", bus.tx_idle, 1);

        // Enqueue while full on the dequeue edge
        do_reset();
        check("overflow_cleared", bus.tx_overflow, 0);
        enqueue(8'hF0, 1'b0);
        for (int i = 0; i < 8; i++) enqueue(tbl[i], 1'b1);
        check("full_before_drop", bus.tx_fifo_full, 1);
        repeat (FRAME_CLKS - 8) @(negedge clk);
        enqueue(8'h99, 1'b0);
        check("drop_overflow",    bus.tx_overflow, 1);
        check("drop_occ7_full",   bus.tx_fifo_full, 0);
        check("drop_occ7_empty",  bus.tx_fifo_empty, 0);
        check_frame("after_drop_frame", v);

        // Reset mid-frame with bytes queued
        do_reset();
        enqueue(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) enqueue(tbl[i + 3], 1'b0);
        repeat (9) @(negedge clk);
        check("midframe_line_low", uart_tx, 0);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_uart_tx", uart_tx, 1);
        check("mid_rst_empty",   bus.tx_fifo_empty, 1);
        check("mid_rst_full",    bus.tx_fifo_full, 0);
        check("mid_rst_idle",    bus.tx_idle, 1);
        check("mid_rst_state",   tx_state, IDLE);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        capture(60, v);
        check("no_frames_after_rst", v, ones60);

`ifdef UART_TX_PARITY_EN
        // Even parity bit
        enqueue(8'h07, 1'b1);
        @(negedge clk);
        check_frame("frame_par_07", v);
        check("par_07_bit", v[9*BAUD+1], 1);
        check("idle_after_44", bus.tx_idle, 1);
        enqueue(8'h03, 1'b1);
        @(negedge clk);
        check_frame("frame_par_03", v);
        check("par_03_bit", v[9*BAUD+1], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
